hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage 16-bit RISC core. It tracks in-flight destination registers for the EX and MEM stages and generates registered ALU operand forwarding selects for the execute stage. It also issues load-use stalls, taken-branch flushes and whole-pipeline freezes for a slow data memory. It sits beside the decode stage and drives the PC, IF/ID and ID/EX pipeline-register controls.

## Interface
- FLUSH_CYCLES, 1: cycles IF/ID and ID/EX are flushed after a taken branch (1..3)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID slot holds a real instruction
- id_src1, id_src2  in  3  source register addresses in ID
- id_use_src1, id_use_src2  in  1  instruction actually reads that source
- id_reg_write  in  1  ID instruction writes a register
- id_mem_read  in  1  ID instruction is a load
- id_dst  in  3  ID destination register
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_wait  in  1  data memory not ready; freeze pipeline
- pc_write_en  out  1  PC may advance
- ifid_write_en  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a bubble
- idex_bubble  out  1  ID/EX loads a bubble (control bits zero)
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- fwd_sel1, fwd_sel2  out  2  EX operand source: 00 reg file, 01 EX/MEM result, 10 MEM/WB write-back data

## Operation
- Scoreboard: two entries, EX slot and MEM slot, each {valid, reg_write, mem_read, dst}. On advance: MEM slot ← EX slot; EX slot ← ID info, or invalid if a bubble is inserted. When frozen, both slots hold.
- Hazard match: a slot matches source s when slot.valid & slot.reg_write & slot.dst == s & use_s. All 8 registers are writable; R0 is not special.
- Load-use: id_valid & EX slot matches src1 or src2 & EX slot.mem_read.
- Forwarding, computed in ID and registered into fwd_sel on advance: an EX-slot match gives 01; else a MEM-slot match gives 10; else 00. The newer producer wins. Bubble cycles register 00.
- FSM states, encoded in the package: RUN, LOAD_STALL, FLUSH, with a 2-bit flush counter.
  - RUN: taken branch → FLUSH, counter = FLUSH_CYCLES−1. Else load-use → LOAD_STALL. Else advance.
  - LOAD_STALL, exactly one cycle: pc_write_en=0, ifid_write_en=0, idex_bubble=1. Then → RUN. The load is now in the MEM slot, so the dependent instruction gets forwarding select 10.
  - FLUSH: ifid_flush=1, idex_bubble=1, pc_write_en=1 (target loads). Decrement the counter; at 0 → RUN.
- Priority, applied every cycle: reset > mem_wait > ex_branch_taken > load-use > normal.
  - mem_wait: pipe_freeze=1, pc_write_en=0, ifid_write_en=0. FSM state, counter, scoreboard and fwd_sel all hold.
  - A taken branch during LOAD_STALL aborts the stall and enters FLUSH.
  - A taken branch while already in FLUSH reloads the counter.
- Outputs are combinational from the state and current inputs, except fwd_sel1/2 and the scoreboard, which are registered.

## Timing
- Reset (asynchronous): state RUN, counter 0, scoreboard invalid, fwd_sel1/2=00.
  - Reset output values: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
  - Reset mid-stall or mid-flush returns immediately to these values.
- Stall and flush decisions take effect in the same cycle as the triggering inputs (zero latency).
- Forwarding select latency: one cycle. The select is valid during the EX cycle of the consuming instruction.
- Load-use costs exactly one bubble. A taken branch costs FLUSH_CYCLES bubbles.
- A mem_wait of N cycles extends any state by exactly N cycles.

## Structure
- Shared package (pipeline package): fsm state typedef, forwarding select constants FWD_RF/FWD_EXMEM/FWD_MEMWB, REG_ADDR_W=3, DATA_W=16.
- One sub-module, hazard_scoreboard: the two-slot shift register plus match and forwarding-select logic. The FSM and output decode stay in the top module.

## Test plan
- ADD R1 followed by SUB using R1 as src2: fwd_sel2=01 in SUB's EX cycle, no stall. With one instruction in between: fwd_sel2=10.
- LOAD R3 followed by ADD reading R3 as src1: one cycle with pc_write_en=0 and idex_bubble=1. Then fwd_sel1=10; total 1 bubble.
- ex_branch_taken pulse with FLUSH_CYCLES=2: ifid_flush=1 and idex_bubble=1 for exactly 2 cycles, pc_write_en=1 throughout.
- mem_wait held 3 cycles during LOAD_STALL: pipe_freeze=1 for 3 cycles, then the remaining stall cycle completes. fwd_sel is unchanged across the freeze.
- Same-cycle load-use and ex_branch_taken: FLUSH is entered and no LOAD_STALL follows.
- reset asserted mid-FLUSH: outputs return to reset values asynchronously. The next dependent ADD→SUB pair still gives fwd_sel=01.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions for the 5-stage 16-bit core's hazard control.
package hazard_controller_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FWD_W      = 2;
  localparam int unsigned FCNT_W     = 2;

  // EX operand source selects
  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_e;

  // One in-flight producer tracked by the scoreboard
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] dst;
  } sb_slot_t;

  // A slot supplies source src when it will write that register and the source is read
  function automatic logic slot_match(input sb_slot_t slot,
                                      input logic [REG_ADDR_W-1:0] src,
                                      input logic use_src);
    return slot.valid & slot.reg_write & use_src & (slot.dst == src);
  endfunction

  // Newer producer (EX slot) wins over the older one (MEM slot)
  function automatic logic [FWD_W-1:0] fwd_select(input sb_slot_t ex_slot,
                                                  input sb_slot_t mem_slot,
                                                  input logic [REG_ADDR_W-1:0] src,
                                                  input logic use_src);
    if (slot_match(ex_slot, src, use_src)) begin
      return FWD_EXMEM;
    end else if (slot_match(mem_slot, src, use_src)) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot destination scoreboard (EX, MEM) with load-use detect and registered forwarding selects.
module hazard_scoreboard
  import hazard_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_advance,
  input  logic                  i_bubble,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_id_use_src1,
  input  logic                  i_id_use_src2,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic [REG_ADDR_W-1:0] i_id_dst,
  output logic                  o_load_use_c,
  output logic [FWD_W-1:0]      o_fwd_sel1,
  output logic [FWD_W-1:0]      o_fwd_sel2
);

  sb_slot_t r_ex_slot;
  sb_slot_t r_mem_slot;
  sb_slot_t w_id_slot;
  logic     w_ex_hit;

  // Pack the ID instruction as a candidate EX-slot entry
  always_comb begin
    w_id_slot.valid     = i_id_valid;
    w_id_slot.reg_write = i_id_reg_write;
    w_id_slot.mem_read  = i_id_mem_read;
    w_id_slot.dst       = i_id_dst;
  end

  // A load in EX feeding the ID instruction cannot be forwarded in time
  always_comb begin
    w_ex_hit     = slot_match(r_ex_slot, i_id_src1, i_id_use_src1) |
                   slot_match(r_ex_slot, i_id_src2, i_id_use_src2);
    o_load_use_c = i_id_valid & w_ex_hit & r_ex_slot.mem_read;
  end

  // Shift slots and register selects on advance; everything holds while frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_slot  <= '0;
      r_mem_slot <= '0;
      o_fwd_sel1 <= FWD_RF;
      o_fwd_sel2 <= FWD_RF;
    end else if (i_advance) begin
      r_mem_slot <= r_ex_slot;
      if (i_bubble) begin
        r_ex_slot  <= '0;
        o_fwd_sel1 <= FWD_RF;
        o_fwd_sel2 <= FWD_RF;
      end else begin
        r_ex_slot  <= w_id_slot;
        o_fwd_sel1 <= fwd_select(r_ex_slot, r_mem_slot, i_id_src1, i_id_use_src1);
        o_fwd_sel2 <= fwd_select(r_ex_slot, r_mem_slot, i_id_src2, i_id_use_src2);
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stall, branch flush, memory freeze and forwarding.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  ex_branch_taken,
  input  logic                  mem_wait,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  pipe_freeze,
  output logic [FWD_W-1:0]      fwd_sel1,
  output logic [FWD_W-1:0]      fwd_sel2
);

  // The branch cycle itself is the first flush cycle; the counter holds the ones still to come
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic              MULTI_FLUSH  = (FLUSH_CYCLES > 32'd1);

  state_e            r_state;
  state_e            w_state_eff;
  state_e            w_state_next;
  logic [FCNT_W-1:0] r_flush_cnt;
  logic [FCNT_W-1:0] w_flush_cnt_next;
  logic              w_load_use;

  hazard_scoreboard u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .i_advance      (~mem_wait),
    .i_bubble       (idex_bubble),
    .i_id_valid     (id_valid),
    .i_id_src1      (id_src1),
    .i_id_src2      (id_src2),
    .i_id_use_src1  (id_use_src1),
    .i_id_use_src2  (id_use_src2),
    .i_id_reg_write (id_reg_write),
    .i_id_mem_read  (id_mem_read),
    .i_id_dst       (id_dst),
    .o_load_use_c   (w_load_use),
    .o_fwd_sel1     (fwd_sel1),
    .o_fwd_sel2     (fwd_sel2)
  );

  // FSM state and flush counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  // Next state and same-cycle control outputs; a load-use seen in RUN is a stall cycle right now
  always_comb begin
    w_state_eff      = r_state;
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    pc_write_en      = 1'b1;
    ifid_write_en    = 1'b1;
    ifid_flush       = 1'b0;
    idex_bubble      = 1'b0;
    pipe_freeze      = 1'b0;

    if ((r_state == ST_RUN) && w_load_use) begin
      w_state_eff = ST_LOAD_STALL;
    end

    if (reset) begin
      w_state_next     = ST_RUN;
      w_flush_cnt_next = '0;
    end else if (mem_wait) begin
      // Freeze: remember which kind of cycle was interrupted so it completes afterwards
      pipe_freeze   = 1'b1;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      w_state_next  = w_state_eff;
    end else if (ex_branch_taken) begin
      ifid_flush       = 1'b1;
      idex_bubble      = 1'b1;
      w_flush_cnt_next = FLUSH_RELOAD;
      w_state_next     = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
    end else begin
      unique case (w_state_eff)
        ST_RUN: begin
          w_state_next = ST_RUN;
        end
        ST_LOAD_STALL: begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_bubble   = 1'b1;
          w_state_next  = ST_RUN;
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (r_flush_cnt > FCNT_W'(1)) begin
            w_flush_cnt_next = r_flush_cnt - FCNT_W'(1);
            w_state_next     = ST_FLUSH;
          end else begin
            w_flush_cnt_next = '0;
            w_state_next     = ST_RUN;
          end
        end
        default: begin
          w_state_next = ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random traffic vs. a pipeline model.
module tb_hazard_controller;

  localparam int unsigned FC = 2;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_src1;
  logic [2:0] id_src2;
  logic       id_use_src1;
  logic       id_use_src2;
  logic       id_reg_write;
  logic       id_mem_read;
  logic [2:0] id_dst;
  logic       ex_branch_taken;
  logic       mem_wait;
  logic       pc_write_en;
  logic       ifid_write_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       pipe_freeze;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;

  hazard_controller #(.FLUSH_CYCLES(FC)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_use_src1     (id_use_src1),
    .id_use_src2     (id_use_src2),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_dst          (id_dst),
    .ex_branch_taken (ex_branch_taken),
    .mem_wait        (mem_wait),
    .pc_write_en     (pc_write_en),
    .ifid_write_en   (ifid_write_en),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .pipe_freeze     (pipe_freeze),
    .fwd_sel1        (fwd_sel1),
    .fwd_sel2        (fwd_sel2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] src1;
    logic [2:0] src2;
    logic       use1;
    logic       use2;
    logic       rw;
    logic       mr;
    logic [2:0] dst;
  } ins_t;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [2:0] dst;
  } mslot_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: instructions in EX and MEM, flush cycles still owed, registered selects
  mslot_t     m_ex, m_mem;
  int         flush_left;
  logic [1:0] m_fwd1, m_fwd2;
  logic       m_ifid_we, m_flush;

  task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic ins_t mk(logic v, logic [2:0] d, logic [2:0] s1, logic u1,
                              logic [2:0] s2, logic u2, logic rw, logic mr);
    ins_t r;
    r.valid = v; r.dst = d; r.src1 = s1; r.use1 = u1;
    r.src2 = s2; r.use2 = u2; r.rw = rw; r.mr = mr;
    return r;
  endfunction

  function automatic ins_t alu(logic [2:0] d, logic [2:0] a, logic [2:0] b);
    return mk(1'b1, d, a, 1'b1, b, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic ins_t ld(logic [2:0] d, logic [2:0] base);
    return mk(1'b1, d, base, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic logic hits(mslot_t s, logic [2:0] src, logic u);
    return s.v && s.rw && u && (s.dst == src);
  endfunction

  function automatic logic [1:0] fwd_of(logic [2:0] src, logic u);
    if (hits(m_ex, src, u)) return 2'b01;
    if (hits(m_mem, src, u)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; flush_left = 0;
    m_fwd1 = 2'b00; m_fwd2 = 2'b00;
    m_ifid_we = 1'b1; m_flush = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check against the model, then retire the model's cycle
  task automatic step(input ins_t ins, input logic br, input logic mw);
    logic lu, e_pc, e_ifid, e_fl, e_bub, e_frz;
    mslot_t ns;
    logic [1:0] n1, n2;
    @(negedge clk);
    id_valid = ins.valid; id_src1 = ins.src1; id_src2 = ins.src2;
    id_use_src1 = ins.use1; id_use_src2 = ins.use2;
    id_reg_write = ins.rw; id_mem_read = ins.mr; id_dst = ins.dst;
    ex_branch_taken = br; mem_wait = mw;
    #1;
    lu = ins.valid && m_ex.mr && (hits(m_ex, ins.src1, ins.use1) || hits(m_ex, ins.src2, ins.use2));
    e_pc = 1'b1; e_ifid = 1'b1; e_fl = 1'b0; e_bub = 1'b0; e_frz = 1'b0;
    if (mw) begin
      e_frz = 1'b1; e_pc = 1'b0; e_ifid = 1'b0;
    end else begin
      if (br) flush_left = FC;
      if (flush_left > 0) begin
        e_fl = 1'b1; e_bub = 1'b1; flush_left--;
      end else if (lu) begin
        e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
      end
    end
    check_eq("pc_write_en", {1'b0, pc_write_en}, {1'b0, e_pc});
    check_eq("ifid_write_en", {1'b0, ifid_write_en}, {1'b0, e_ifid});
    check_eq("ifid_flush", {1'b0, ifid_flush}, {1'b0, e_fl});
    check_eq("idex_bubble", {1'b0, idex_bubble}, {1'b0, e_bub});
    check_eq("pipe_freeze", {1'b0, pipe_freeze}, {1'b0, e_frz});
    check_eq("fwd_sel1", fwd_sel1, m_fwd1);
    check_eq("fwd_sel2", fwd_sel2, m_fwd2);
    if (!mw) begin
      n1 = e_bub ? 2'b00 : fwd_of(ins.src1, ins.use1);
      n2 = e_bub ? 2'b00 : fwd_of(ins.src2, ins.use2);
      ns = '0;
      if (!e_bub) begin
        ns.v = ins.valid; ns.rw = ins.rw; ns.mr = ins.mr; ns.dst = ins.dst;
      end
      m_mem = m_ex; m_ex = ns; m_fwd1 = n1; m_fwd2 = n2;
    end
    m_ifid_we = e_ifid;
    m_flush = e_fl;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pc"}, {1'b0, pc_write_en}, 2'b01);
    check_eq({tag, "_ifid"}, {1'b0, ifid_write_en}, 2'b01);
    check_eq({tag, "_flush"}, {1'b0, ifid_flush}, 2'b00);
    check_eq({tag, "_bubble"}, {1'b0, idex_bubble}, 2'b00);
    check_eq({tag, "_freeze"}, {1'b0, pipe_freeze}, 2'b00);
    check_eq({tag, "_fwd1"}, fwd_sel1, 2'b00);
    check_eq({tag, "_fwd2"}, fwd_sel2, 2'b00);
  endtask

  function automatic logic [2:0] rnd_reg();
    return $urandom_range(0, 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
  endfunction

  initial begin
    ins_t cur;
    logic hold, bubble_next, br, mw;

    reset = 1'b1;
    id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_dst = '0;
    ex_branch_taken = 1'b0; mem_wait = 1'b0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Back-to-back ALU dependency, then one instruction apart
    step(alu(3'd1, 3'd2, 3'd3), 1'b0, 1'b0);
    step(alu(3'd4, 3'd5, 3'd1), 1'b0, 1'b0);
    check_eq("addsub_nostall", {1'b0, pc_write_en}, 2'b01);
    step(nop(), 1'b0, 1'b0);
    check_eq("addsub_fwd2", fwd_sel2, 2'b01);
    check_eq("addsub_fwd1", fwd_sel1, 2'b00);
    step(alu(3'd1, 3'd2, 3'd3), 1'b0, 1'b0);
    step(alu(3'd6, 3'd2, 3'd2), 1'b0, 1'b0);
    step(alu(3'd4, 3'd5, 3'd1), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b0);
    check_eq("gap1_fwd2", fwd_sel2, 2'b10);

    // Load-use: one bubble, then MEM/WB forwarding
    step(ld(3'd3, 3'd0), 1'b0, 1'b0);
    step(alu(3'd5, 3'd3, 3'd6), 1'b0, 1'b0);
    check_eq("lu_pc", {1'b0, pc_write_en}, 2'b00);
    check_eq("lu_bubble", {1'b0, idex_bubble}, 2'b01);
    step(alu(3'd5, 3'd3, 3'd6), 1'b0, 1'b0);
    check_eq("lu_once_pc", {1'b0, pc_write_en}, 2'b01);
    check_eq("lu_once_bubble", {1'b0, idex_bubble}, 2'b00);
    step(nop(), 1'b0, 1'b0);
    check_eq("lu_fwd1", fwd_sel1, 2'b10);

    // Taken branch flushes exactly FC cycles
    step(nop(), 1'b1, 1'b0);
    check_eq("br_flush0", {1'b0, ifid_flush}, 2'b01);
    check_eq("br_pc0", {1'b0, pc_write_en}, 2'b01);
    step(nop(), 1'b0, 1'b0);
    check_eq("br_flush1", {1'b0, ifid_flush}, 2'b01);
    check_eq("br_bubble1", {1'b0, idex_bubble}, 2'b01);
    step(nop(), 1'b0, 1'b0);
    check_eq("br_flush_end", {1'b0, ifid_flush}, 2'b00);

    // Freeze in the middle of a load-use stall
    step(alu(3'd7, 3'd1, 3'd1), 1'b0, 1'b0);
    step(ld(3'd5, 3'd7), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(alu(3'd7, 3'd1, 3'd5), 1'b0, 1'b1);
      check_eq("frz_freeze", {1'b0, pipe_freeze}, 2'b01);
      check_eq("frz_fwd1_hold", fwd_sel1, 2'b01);
    end
    step(alu(3'd7, 3'd1, 3'd5), 1'b0, 1'b0);
    check_eq("frz_stall_pc", {1'b0, pc_write_en}, 2'b00);
    check_eq("frz_stall_bubble", {1'b0, idex_bubble}, 2'b01);
    check_eq("frz_fwd1_after", fwd_sel1, 2'b01);
    step(alu(3'd7, 3'd1, 3'd5), 1'b0, 1'b0);
    check_eq("frz_resume_pc", {1'b0, pc_write_en}, 2'b01);
    step(nop(), 1'b0, 1'b0);
    check_eq("frz_fwd2", fwd_sel2, 2'b10);

    // Load-use and taken branch together: branch wins, no stall afterwards
    step(ld(3'd2, 3'd0), 1'b0, 1'b0);
    step(alu(3'd6, 3'd2, 3'd3), 1'b1, 1'b0);
    check_eq("lubr_flush", {1'b0, ifid_flush}, 2'b01);
    check_eq("lubr_pc", {1'b0, pc_write_en}, 2'b01);
    step(nop(), 1'b0, 1'b0);
    check_eq("lubr_flush1", {1'b0, ifid_flush}, 2'b01);
    step(nop(), 1'b0, 1'b0);
    check_eq("lubr_after_pc", {1'b0, pc_write_en}, 2'b01);
    check_eq("lubr_after_bubble", {1'b0, idex_bubble}, 2'b00);

    // Asynchronous reset in the middle of a flush
    step(nop(), 1'b1, 1'b0);
    @(posedge clk);
    #2;
    mem_wait = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midflush_reset");
    model_reset();
    ex_branch_taken = 1'b0;
    mem_wait = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    step(alu(3'd1, 3'd2, 3'd3), 1'b0, 1'b0);
    step(alu(3'd4, 3'd5, 3'd1), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b0);
    check_eq("post_reset_fwd2", fwd_sel2, 2'b01);

    // Random traffic; ID holds its instruction whenever IF/ID did not load
    cur = nop();
    hold = 1'b0;
    bubble_next = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        cur = mk(($urandom_range(0, 7) != 0), rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)),
                 rnd_reg(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0));
        if (bubble_next) cur.valid = 1'b0;
      end
      br = ($urandom_range(0, 9) == 0);
      mw = ($urandom_range(0, 5) == 0);
      step(cur, br, mw);
      hold = !m_ifid_we;
      bubble_next = m_flush;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
